fft_frame_sequencer: RTL and testbench

//  Frames an unframed complex sample stream into FFT-length Avalon-ST packets (SOP/EOP), sits upstream of the FFT data adapter.

---
 rtl/fft_seq_pkg.sv | 20 ++
 rtl/fft_seq_skid_buffer.sv | 46 ++++
 rtl/fft_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_fft_frame_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared state type, default sizes and frame-length clamp for the FFT frame sequencer
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAD
    } seq_state_e;

    localparam int SYMBOL_WIDTH_DEF = 16;
    localparam int MAX_LOG2_LEN_DEF = 12;
    localparam int MIN_LOG2_LEN_DEF = 3;
    localparam int FRAME_CNT_W      = 16;

    // Requested log2 length forced into the supported [lo, hi] window
    function automatic logic [3:0] clamp_log2(input logic [3:0] v, input int lo, input int hi);
        return (int'(v) < lo) ? 4'(lo) : (int'(v) > hi) ? 4'(hi) : v;
    endfunction

endpackage

// File: rtl/fft_seq_skid_buffer.sv
// fft_seq_skid_buffer: 2-entry registered skid buffer; in_ready_o comes straight from a flop
module fft_seq_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             push;

    assign in_ready_o  = !skid_valid_q;
    assign push        = in_valid_i && in_ready_o;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = out_valid_q || skid_valid_q;

    // Output register refills from the skid entry first; the skid entry only catches a beat during a stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q   <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            out_valid_q  <= skid_valid_q || push;
            skid_valid_q <= 1'b0;
            if (skid_valid_q) out_data_q <= skid_data_q;
            else if (push) out_data_q <= in_data_i;
        end else if (push) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data_i;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames a complex sample stream into SOP/EOP packets; FFT_SEQ_ZERO_PAD_EN zero-pads a stopped frame
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
    parameter int MAX_LOG2_LEN = MAX_LOG2_LEN_DEF,
    parameter int MIN_LOG2_LEN = MIN_LOG2_LEN_DEF
) (
    input  logic                        clock_clk,
    input  logic                        reset_reset,
    input  logic [2*SYMBOL_WIDTH-1:0]   asi_in_data,
    input  logic                        asi_in_valid,
    output logic                        asi_in_ready,
    output logic [2*SYMBOL_WIDTH-1:0]   aso_out_data,
    output logic                        aso_out_valid,
    output logic                        aso_out_startofpacket,
    output logic                        aso_out_endofpacket,
    output logic                        aso_out_inverse,
    input  logic                        aso_out_ready,
    input  logic [3:0]                  cfg_log2_len,
    input  logic                        cfg_inverse,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    output logic                        status_busy,
    output logic [FRAME_CNT_W-1:0]      status_frame_count
);

    localparam int DW = 2 * SYMBOL_WIDTH;
    localparam int PW = DW + 3;

    seq_state_e             state_q;
    logic [3:0]             len_q;
    logic                   inv_q;
    logic                   stop_pending_q;
    logic [MAX_LOG2_LEN-1:0] idx_q;
    logic [MAX_LOG2_LEN-1:0] last_idx;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   skid_ready;
    logic                   skid_busy;
    logic                   push;
    logic                   eop;
    logic [DW-1:0]          push_data;
    logic [PW-1:0]          push_payload;
    logic [PW-1:0]          out_payload;

    // Last index of a 2**len frame; a full-width shift wraps to zero and the subtraction yields all ones
    assign last_idx     = (MAX_LOG2_LEN'(1) << len_q) - MAX_LOG2_LEN'(1);
    assign eop          = idx_q == last_idx;
    assign asi_in_ready = (state_q == RUN) && skid_ready;
`ifdef FFT_SEQ_ZERO_PAD_EN
    assign push      = (asi_in_valid && asi_in_ready) || (state_q == PAD && skid_ready);
    assign push_data = (state_q == PAD) ? '0 : asi_in_data;
`else
    assign push      = asi_in_valid && asi_in_ready;
    assign push_data = asi_in_data;
`endif
    assign push_payload = {push_data, idx_q == '0, eop, inv_q};

    fft_seq_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .clk_i      (clock_clk),
        .rst_i      (reset_reset),
        .in_data_i  (push_payload),
        .in_valid_i (push),
        .in_ready_o (skid_ready),
        .out_data_o (out_payload),
        .out_valid_o(aso_out_valid),
        .out_ready_i(aso_out_ready),
        .busy_o     (skid_busy)
    );

    assign aso_out_data          = out_payload[PW-1:3];
    assign aso_out_startofpacket = out_payload[2];
    assign aso_out_endofpacket   = out_payload[1];
    assign aso_out_inverse       = out_payload[0];
    assign status_busy           = (state_q != IDLE) || skid_busy;
    assign status_frame_count    = frame_cnt_q;

    // Framing FSM: frame config is latched only at frame start so mid-frame cfg changes wait for the next SOP
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q        <= IDLE;
            len_q          <= 4'(MIN_LOG2_LEN);
            inv_q          <= 1'b0;
            idx_q          <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start && !cfg_stop) begin
                        state_q <= RUN;
                        len_q   <= clamp_log2(cfg_log2_len, MIN_LOG2_LEN, MAX_LOG2_LEN);
                        inv_q   <= cfg_inverse;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (push && eop) begin
                        idx_q          <= '0;
                        stop_pending_q <= 1'b0;
                        if (stop_pending_q || cfg_stop) begin
                            state_q <= IDLE;
                        end else begin
                            len_q <= clamp_log2(cfg_log2_len, MIN_LOG2_LEN, MAX_LOG2_LEN);
                            inv_q <= cfg_inverse;
                        end
                    end else begin
                        if (push) idx_q <= idx_q + 1'b1;
                        if (cfg_stop) begin
`ifdef FFT_SEQ_ZERO_PAD_EN
                            state_q <= (push || idx_q != '0) ? PAD : IDLE;
`else
                            if (!push && idx_q == '0) state_q <= IDLE;
                            else stop_pending_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FFT_SEQ_ZERO_PAD_EN
                PAD: begin
                    if (push) begin
                        idx_q <= eop ? '0 : idx_q + 1'b1;
                        if (eop) state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completed frames are counted when the EOP beat leaves downstream, not when it enters
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) frame_cnt_q <= '0;
        else if (aso_out_valid && aso_out_ready && aso_out_endofpacket) frame_cnt_q <= frame_cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed/random stimulus against a queue-based framing model
module tb_fft_frame_sequencer;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic        inv;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] asi_in_data = '0;
    logic        asi_in_valid = 1'b0;
    logic        asi_in_ready;
    logic [31:0] aso_out_data;
    logic        aso_out_valid;
    logic        aso_out_startofpacket;
    logic        aso_out_endofpacket;
    logic        aso_out_inverse;
    logic        aso_out_ready;
    logic [3:0]  cfg_log2_len = 4'd3;
    logic        cfg_inverse = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        status_busy;
    logic [15:0] status_frame_count;

    int    tests = 0;
    int    fails = 0;
    int    ready_mode = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    int    m_pos = 0;
    int    m_n = 8;
    int    m_frames = 0;
    logic  m_inv = 1'b0;
    logic  m_run = 1'b0;
    logic  m_pend = 1'b0;

    fft_frame_sequencer dut (
        .clock_clk            (clk),
        .reset_reset          (rst),
        .asi_in_data          (asi_in_data),
        .asi_in_valid         (asi_in_valid),
        .asi_in_ready         (asi_in_ready),
        .aso_out_data         (aso_out_data),
        .aso_out_valid        (aso_out_valid),
        .aso_out_startofpacket(aso_out_startofpacket),
        .aso_out_endofpacket  (aso_out_endofpacket),
        .aso_out_inverse      (aso_out_inverse),
        .aso_out_ready        (aso_out_ready),
        .cfg_log2_len         (cfg_log2_len),
        .cfg_inverse          (cfg_inverse),
        .cfg_start            (cfg_start),
        .cfg_stop             (cfg_stop),
        .status_busy          (status_busy),
        .status_frame_count   (status_frame_count)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        aso_out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: logs every downstream transfer and checks that a stalled beat is held unchanged
    initial begin
        beat_t cur;
        beat_t prev;
        logic  prev_stall;
        prev = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur = '{aso_out_data, aso_out_startofpacket, aso_out_endofpacket, aso_out_inverse};
                if (prev_stall) begin
                    check("stall_valid", 64'(aso_out_valid), 64'd1);
                    check("stall_hold", 64'(cur), 64'(prev));
                end
                if (aso_out_valid && aso_out_ready) obs_q.push_back(cur);
                prev_stall = aso_out_valid && !aso_out_ready;
                prev = cur;
            end
        end
    end

    function automatic int frame_len(input logic [3:0] v);
        int l;
        l = (v < 3) ? 3 : (v > 12) ? 12 : int'(v);
        return 1 << l;
    endfunction

    function automatic void model_accept(input logic [31:0] d);
        exp_q.push_back('{d, m_pos == 0, m_pos == m_n - 1, m_inv});
        if (m_pos == m_n - 1) begin
            m_frames++;
            m_pos = 0;
            if (m_pend || cfg_stop) begin
                m_run = 1'b0;
                m_pend = 1'b0;
            end else begin
                m_n = frame_len(cfg_log2_len);
                m_inv = cfg_inverse;
            end
        end else begin
            m_pos++;
        end
    endfunction

    function automatic void model_stop();
        if (!m_run) return;
`ifdef FFT_SEQ_ZERO_PAD_EN
        if (m_pos != 0) begin
            for (int p = m_pos; p < m_n; p++) exp_q.push_back('{32'd0, 1'b0, p == m_n - 1, m_inv});
            m_frames++;
        end
        m_run = 1'b0;
        m_pos = 0;
`else
        if (m_pos == 0) m_run = 1'b0;
        else m_pend = 1'b1;
`endif
    endfunction

    task automatic start_frame();
        @(negedge clk);
        cfg_start = 1'b1;
        m_run = 1'b1;
        m_pos = 0;
        m_pend = 1'b0;
        m_n = frame_len(cfg_log2_len);
        m_inv = cfg_inverse;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic send(input int n, input int stop_at, output int got);
        bit stopped;
        stopped = 1'b0;
        got = 0;
        for (int t = 0; t < 4 * n + 200 && got < n; t++) begin
            @(negedge clk);
            asi_in_valid = 1'b1;
            asi_in_data = $urandom;
            cfg_stop = (got == stop_at) && !stopped;
            stopped |= cfg_stop;
            if (asi_in_ready) begin
                got++;
                model_accept(asi_in_data);
            end
            if (cfg_stop) model_stop();
            @(posedge clk);
            #1;
            cfg_stop = 1'b0;
        end
        asi_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20000 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        check({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        check({tag, "_frames"}, 64'(status_frame_count), 64'(m_frames));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        m_run = 1'b0;
        m_pos = 0;
        m_pend = 1'b0;
        m_frames = 0;
    endtask

    initial begin
        int got;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(aso_out_valid), 64'd0);
        check("rst_in_ready", 64'(asi_in_ready), 64'd0);
        check("rst_busy", 64'(status_busy), 64'd0);
        check("rst_count", 64'(status_frame_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // start and stop together leave the sequencer idle
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_stop = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        @(negedge clk);
        check("startstop_ready", 64'(asi_in_ready), 64'd0);
        check("startstop_busy", 64'(status_busy), 64'd0);

        // two full 8-sample frames plus a partial third
        cfg_log2_len = 4'd3;
        cfg_inverse = 1'b0;
        start_frame();
        send(20, -1, got);
        check("t1_got", 64'(got), 64'd20);
        drain();
        check("t1_sop0", 64'(obs_q[0].sop), 64'd1);
        check("t1_eop7", 64'(obs_q[7].eop), 64'd1);
        check("t1_sop8", 64'(obs_q[8].sop), 64'd1);
        check("t1_eop15", 64'(obs_q[15].eop), 64'd1);
        check("t1_sop16", 64'(obs_q[16].sop), 64'd1);
        check("t1_eop19", 64'(obs_q[19].eop), 64'd0);
        check("t1_count", 64'(status_frame_count), 64'd2);
        verify("t1");

        // random downstream backpressure over four 16-sample frames
        do_reset();
        cfg_log2_len = 4'd4;
        cfg_inverse = 1'b1;
        ready_mode = 1;
        start_frame();
        send(64, -1, got);
        check("t2_got", 64'(got), 64'd64);
        ready_mode = 0;
        drain();
        check("t2_count", 64'(status_frame_count), 64'd4);
        verify("t2");

        // stop requested while sample 5 of an 8-sample frame is accepted
        do_reset();
        cfg_log2_len = 4'd3;
        cfg_inverse = 1'b1;
        start_frame();
        send(8, 5, got);
`ifdef FFT_SEQ_ZERO_PAD_EN
        check("t4_got", 64'(got), 64'd6);
`else
        check("t3_got", 64'(got), 64'd8);
`endif
        drain();
        check("t3_ready", 64'(asi_in_ready), 64'd0);
        for (int t = 0; t < 50 && status_busy; t++) @(negedge clk);
        check("t3_busy", 64'(status_busy), 64'd0);
        check("t3_count", 64'(status_frame_count), 64'd1);
        check("t3_eop7", 64'(obs_q[7].eop), 64'd1);
`ifdef FFT_SEQ_ZERO_PAD_EN
        check("t4_pad6", 64'(obs_q[6].d), 64'd0);
        check("t4_pad7", 64'(obs_q[7].d), 64'd0);
`endif
        verify("t3");

        // clamped lengths and mid-frame cfg changes
        do_reset();
        cfg_log2_len = 4'd1;
        cfg_inverse = 1'b0;
        start_frame();
        send(4, -1, got);
        cfg_inverse = 1'b1;
        cfg_log2_len = 4'd15;
        send(4, -1, got);
        send(100, -1, got);
        cfg_inverse = 1'b0;
        send(3996, -1, got);
        send(2, -1, got);
        drain();
        check("t5_eop7", 64'(obs_q[7].eop), 64'd1);
        check("t5_inv7", 64'(obs_q[7].inv), 64'd0);
        check("t5_sop8", 64'(obs_q[8].sop), 64'd1);
        check("t5_inv8", 64'(obs_q[8].inv), 64'd1);
        check("t5_eop4103", 64'(obs_q[4103].eop), 64'd1);
        check("t5_inv4103", 64'(obs_q[4103].inv), 64'd1);
        check("t5_sop4104", 64'(obs_q[4104].sop), 64'd1);
        check("t5_inv4104", 64'(obs_q[4104].inv), 64'd0);
        verify("t5");

        // asynchronous reset with a stalled beat mid-frame
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        send(1, -1, got);
        @(negedge clk);
        check("t6_pre_valid", 64'(aso_out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(aso_out_valid), 64'd0);
        check("t6_data", 64'(aso_out_data), 64'd0);
        check("t6_flags", 64'({aso_out_startofpacket, aso_out_endofpacket, aso_out_inverse}), 64'd0);
        check("t6_ready", 64'(asi_in_ready), 64'd0);
        check("t6_busy", 64'(status_busy), 64'd0);
        check("t6_count", 64'(status_frame_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        m_run = 1'b0;
        m_pos = 0;
        m_pend = 1'b0;
        m_frames = 0;
        ready_mode = 0;
        cfg_log2_len = 4'd3;
        cfg_inverse = 1'b1;
        @(negedge clk);
        start_frame();
        send(8, -1, got);
        drain();
        check("t6_sop0", 64'(obs_q[0].sop), 64'd1);
        check("t6_count_after", 64'(status_frame_count), 64'd1);
        verify("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
